// File: rtl/invader_fleet_ctrl_pkg.sv
// Shared definitions for the invader fleet controller: fleet geometry, FSM states,
// march direction and the slot-clearing helper.
package invader_fleet_ctrl_pkg;

    localparam int FLEET_SLOTS = 20;
    localparam int SLOT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARCH = 2'd1,
        ST_WON   = 2'd2,
        ST_LOST  = 2'd3
    } fleet_state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } fleet_dir_t;

    // Caller guarantees slot < FLEET_SLOTS.
    function automatic logic [FLEET_SLOTS-1:0] clear_slot(
        input logic [FLEET_SLOTS-1:0] arr,
        input logic [SLOT_W-1:0]      slot
    );
        logic [FLEET_SLOTS-1:0] mask;
        mask = {{(FLEET_SLOTS-1){1'b0}}, 1'b1} << slot;
        return arr & ~mask;
    endfunction

endpackage

// File: rtl/invader_fleet_ctrl_step_timer.sv
// March-step divider: counts run cycles and emits a one-cycle tick on the last
// count of each STEP_CYCLES period; clear restarts the period.
module fleet_step_timer #(
    parameter int unsigned STEP_CYCLES = 32'd1200000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (STEP_CYCLES > 32'd1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 32'd1);

    logic [CNT_W-1:0] cnt_r;

    // Period counter, frozen while run is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (run) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = run && !clear && (cnt_r == LAST);

endmodule

// File: rtl/invader_fleet_ctrl.sv
// Invader formation sequencer: marches, drops and reverses the occupancy vector,
// applies bullet hits and reports win/loss to the display and game logic.
module invader_fleet_ctrl
    import invader_fleet_ctrl_pkg::*;
#(
    parameter int unsigned            STEP_CYCLES  = 32'd1200000,
    parameter logic [FLEET_SLOTS-1:0] INIT_PATTERN = 20'b00101010101010101010,
    parameter logic [SLOT_W-1:0]      LINE_MAX     = 5'd20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   enable,
    input  logic                   hit_valid,
    input  logic [SLOT_W-1:0]      hit_slot,
    output logic [FLEET_SLOTS-1:0] invaders_array,
    output logic [SLOT_W-1:0]      invaders_line,
    output logic                   step_pulse,
    output logic                   game_won,
    output logic                   game_lost
);

    localparam logic [SLOT_W-1:0] SLOT_LIMIT = SLOT_W'(FLEET_SLOTS);

    fleet_state_t           state_r;
    fleet_dir_t             dir_r;
    logic [FLEET_SLOTS-1:0] array_r;
    logic [SLOT_W-1:0]      line_r;
    logic                   pulse_r;
    logic                   won_r;
    logic                   lost_r;

    logic                   run_s;
    logic                   tick_s;
    logic                   hit_ok_s;
    logic                   edge_s;
    logic [FLEET_SLOTS-1:0] cleared_s;
    logic [FLEET_SLOTS-1:0] stepped_s;
    logic [FLEET_SLOTS-1:0] next_array_s;

    assign run_s = (state_r == ST_MARCH) && enable;

    fleet_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .run   (run_s),
        .tick  (tick_s)
    );

    // Hit is applied before the edge test so a step sees the already-cleared fleet.
    always_comb begin
        hit_ok_s = hit_valid && (hit_slot < SLOT_LIMIT);
        if (hit_ok_s) begin
            cleared_s = clear_slot(array_r, hit_slot);
        end else begin
            cleared_s = array_r;
        end
        if (dir_r == DIR_RIGHT) begin
            edge_s = cleared_s[FLEET_SLOTS-1];
        end else begin
            edge_s = cleared_s[0];
        end
        if (edge_s) begin
            stepped_s = cleared_s;
        end else if (dir_r == DIR_RIGHT) begin
            stepped_s = {cleared_s[FLEET_SLOTS-2:0], 1'b0};
        end else begin
            stepped_s = {1'b0, cleared_s[FLEET_SLOTS-1:1]};
        end
        if (tick_s) begin
            next_array_s = stepped_s;
        end else begin
            next_array_s = cleared_s;
        end
    end

    // Game FSM with formation state and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            dir_r   <= DIR_RIGHT;
            array_r <= INIT_PATTERN;
            line_r  <= '0;
            pulse_r <= 1'b0;
            won_r   <= 1'b0;
            lost_r  <= 1'b0;
        end else if (start) begin
            state_r <= ST_MARCH;
            dir_r   <= DIR_RIGHT;
            array_r <= INIT_PATTERN;
            line_r  <= '0;
            pulse_r <= 1'b0;
            won_r   <= 1'b0;
            lost_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_MARCH: begin
                    if (array_r == '0) begin
                        state_r <= ST_WON;
                        won_r   <= 1'b1;
                        pulse_r <= 1'b0;
                    end else if (line_r == LINE_MAX) begin
                        state_r <= ST_LOST;
                        lost_r  <= 1'b1;
                        pulse_r <= 1'b0;
                    end else begin
                        array_r <= next_array_s;
                        pulse_r <= tick_s;
                        if (tick_s && edge_s) begin
                            dir_r  <= (dir_r == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                            line_r <= (line_r == LINE_MAX) ? line_r : line_r + 5'd1;
                        end else begin
                            dir_r  <= dir_r;
                            line_r <= line_r;
                        end
                    end
                end
                ST_IDLE, ST_WON, ST_LOST: begin
                    pulse_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    pulse_r <= 1'b0;
                end
            endcase
        end
    end

    assign invaders_array = array_r;
    assign invaders_line  = line_r;
    assign step_pulse     = pulse_r;
    assign game_won       = won_r;
    assign game_lost      = lost_r;

endmodule

// File: tb/tb_invader_fleet_ctrl.sv
// Self-checking bench for invader_fleet_ctrl: directed scenarios plus random play,
// all outputs compared every cycle against a behavioural game model.
module tb_invader_fleet_ctrl;

    localparam int          SC      = 4;
    localparam int unsigned INIT    = 32'h2AAAA;
    localparam int          LMAX    = 20;
    localparam int unsigned FULL    = 32'h100000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        enable = 1'b0;
    logic        hit_valid = 1'b0;
    logic [4:0]  hit_slot = 5'd0;
    logic [19:0] invaders_array;
    logic [4:0]  invaders_line;
    logic        step_pulse;
    logic        game_won;
    logic        game_lost;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: 0 idle, 1 marching, 2 won, 3 lost
    int          m_mode;
    int unsigned m_arr;
    int          m_line;
    int          m_cnt;
    bit          m_left;
    bit          m_pulse;
    bit          m_won;
    bit          m_lost;

    invader_fleet_ctrl #(
        .STEP_CYCLES (SC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .enable         (enable),
        .hit_valid      (hit_valid),
        .hit_slot       (hit_slot),
        .invaders_array (invaders_array),
        .invaders_line  (invaders_line),
        .step_pulse     (step_pulse),
        .game_won       (game_won),
        .game_lost      (game_lost)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_arr = INIT; m_line = 0; m_cnt = 0;
        m_left = 1'b0; m_pulse = 1'b0; m_won = 1'b0; m_lost = 1'b0;
    endtask

    function automatic bit slot_alive(input int unsigned arr, input int slot);
        return ((arr / (32'd1 << slot)) % 2) == 1;
    endfunction

    task automatic model_step(input bit s, input bit e, input bit hv, input int sl);
        bit step;
        int unsigned a;
        m_pulse = 1'b0;
        if (s) begin
            m_mode = 1; m_arr = INIT; m_line = 0; m_left = 1'b0; m_cnt = 0;
            m_won = 1'b0; m_lost = 1'b0;
        end else if (m_mode == 1) begin
            step = e && (m_cnt == SC - 1);
            if (e) m_cnt = (m_cnt + 1) % SC;
            if (m_arr == 0) begin
                m_mode = 2; m_won = 1'b1;
            end else if (m_line == LMAX) begin
                m_mode = 3; m_lost = 1'b1;
            end else begin
                a = m_arr;
                if (hv && sl < 20 && slot_alive(a, sl)) a = a - (32'd1 << sl);
                if (step) begin
                    if ((!m_left && a >= FULL / 2) || (m_left && a % 2 == 1)) begin
                        m_line = (m_line < LMAX) ? m_line + 1 : LMAX;
                        m_left = !m_left;
                    end else if (m_left) begin
                        a = a / 2;
                    end else begin
                        a = a * 2;
                    end
                end
                m_arr = a;
                m_pulse = step;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".array"}, {12'd0, invaders_array}, m_arr);
        check_eq({tag, ".line"},  {27'd0, invaders_line},  m_line);
        check_eq({tag, ".pulse"}, {31'd0, step_pulse},     {31'd0, m_pulse});
        check_eq({tag, ".won"},   {31'd0, game_won},       {31'd0, m_won});
        check_eq({tag, ".lost"},  {31'd0, game_lost},      {31'd0, m_lost});
    endtask

    task automatic cyc(input bit s, input bit e, input bit hv, input int sl);
        start = s; enable = e; hit_valid = hv; hit_slot = 5'(sl);
        @(posedge clk);
        model_step(s, e, hv, sl);
        #1;
        compare_all("cyc");
        start = 1'b0; hit_valid = 1'b0;
    endtask

    task automatic run_to_step_edge();
        int guard = 0;
        while (m_cnt != SC - 1 && guard < 16) begin
            cyc(1'b0, 1'b1, 1'b0, 0);
            guard++;
        end
        check_eq("step_align", m_cnt, SC - 1);
    endtask

    initial begin
        int unsigned frozen;
        int guard;

        model_reset();
        #12;
        compare_all("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1);
        check_eq("idle_hold", {12'd0, invaders_array}, INIT);

        // march, edge drop and reversal
        cyc(1'b1, 1'b1, 1'b0, 0);
        check_eq("start_arr", {12'd0, invaders_array}, 32'h2AAAA);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0);
        check_eq("step1_arr", {12'd0, invaders_array}, 32'h55554);
        check_eq("step1_pulse", {31'd0, step_pulse}, 32'd1);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 0);
        check_eq("step2_arr", {12'd0, invaders_array}, 32'hAAAA8);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 0);
        check_eq("drop_arr", {12'd0, invaders_array}, 32'hAAAA8);
        check_eq("drop_line", {27'd0, invaders_line}, 32'd1);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 0);
        check_eq("left_arr", {12'd0, invaders_array}, 32'h55554);

        // hits
        cyc(1'b1, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1);
        check_eq("hit1_arr", {12'd0, invaders_array}, 32'h2AAA8);
        cyc(1'b1, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 25);
        check_eq("hit25_arr", {12'd0, invaders_array}, 32'h2AAAA);
        run_to_step_edge();
        cyc(1'b0, 1'b1, 1'b1, 1);
        check_eq("hit_step_arr", {12'd0, invaders_array}, 32'h55550);
        cyc(1'b1, 1'b1, 1'b1, 3);
        check_eq("start_hit_arr", {12'd0, invaders_array}, 32'h2AAAA);

        // clear every live slot -> win
        for (int i = 0; i < 20; i++) begin
            if (slot_alive(m_arr, i)) cyc(1'b0, 1'b0, 1'b1, i);
        end
        cyc(1'b0, 1'b1, 1'b0, 0);
        check_eq("won", {31'd0, game_won}, 32'd1);
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        check_eq("won_cleared", {31'd0, game_won}, 32'd0);
        check_eq("restart_arr", {12'd0, invaders_array}, 32'h2AAAA);

        // leave fleet alive until it lands
        guard = 0;
        while (m_mode != 3 && guard < 3000) begin
            cyc(1'b0, 1'b1, 1'b0, 0);
            guard++;
        end
        check_eq("lost", {31'd0, game_lost}, 32'd1);
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 0);
        check_eq("lost_line", {27'd0, invaders_line}, 32'd20);

        // pause freezes the march
        cyc(1'b1, 1'b1, 1'b0, 0);
        repeat (6) cyc(1'b0, 1'b1, 1'b0, 0);
        frozen = m_arr;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 0);
            check_eq("pause_arr", {12'd0, invaders_array}, frozen);
        end

        // random play
        cyc(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 3) == 0, int'($urandom_range(0, 24)));
        end

        // reset with a step about to land
        cyc(1'b1, 1'b1, 1'b0, 0);
        run_to_step_edge();
        enable = 1'b1; hit_valid = 1'b1; hit_slot = 5'd1;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("async_reset");
        check_eq("async_reset_arr", {12'd0, invaders_array}, 32'h2AAAA);
        @(posedge clk); #1;
        compare_all("reset_hold");
        hit_valid = 1'b0;
        reset = 1'b0;
        repeat (8) cyc(1'b0, 1'b1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
